prog_counter_load_arbiter: RTL
==============================

Name: prog_counter_load_arbiter

Overview:
- Shares the programmable 8-bit counter's load port between NREQ requesters.
- Arbitrates requests round-robin and generates the counter's ui_in control bits (en/load/oe).
- Drives the shared bidirectional uio bus with the winner's value only inside the counter's capture window, so bus contention cannot occur.
- Sits between on-chip requesters and the counter: cnt_ctrl_o feeds counter ui_in[2:0]; bus_out_o/bus_oe_o feed the uio pad mux.

Parameters:
- NREQ, 2, number of requesters (2..4).
- CAP_OFS, 3, cycles from load bit rising on cnt_ctrl_o[1] to the counter's capture cycle. Made up of sync flop + edge detect + release turnaround.
- GAP, 1, idle cycles after done before the next grant may issue load.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- run_i  in  1  counter count enable request, registered to cnt_ctrl_o[0]
- drv_i  in  1  counter output-drive request, registered to cnt_ctrl_o[2]
- req_i  in  NREQ  per-requester load request, level
- data_i  in  NREQ*8  per-requester load value, packed, requester i at [8i+7:8i]
- count_i  in  8  counter value (counter uo_out)
- cnt_ctrl_o  out  3  {oe, load, en} to counter ui_in[2:0]
- bus_out_o  out  8  value driven onto uio
- bus_oe_o  out  1  uio output enable for controller drive
- gnt_o  out  NREQ  one-hot grant, held from grant through done
- done_o  out  NREQ  one-cycle pulse, value captured by counter
- busy_o  out  1  load sequence in progress

Behaviour:
- Reset values: cnt_ctrl_o=0, bus_out_o=0, bus_oe_o=0, gnt_o=0, done_o=0, busy_o=0, rr pointer=0.
- Reset assertion mid-sequence clears bus_oe_o asynchronously and returns the FSM to IDLE. No done is issued.
- cnt_ctrl_o[0] = run_i registered; cnt_ctrl_o[2] = drv_i registered. Each has 1-cycle latency.
- FSM states: IDLE, LOAD, WAIT, DRIVE, DONE, GAP.
- IDLE:
  - Any req_i high -> arbiter picks the winner.
  - Next cycle: state LOAD, gnt_o one-hot, busy_o=1, data latched into bus_out_o.
- LOAD (cycle L): cnt_ctrl_o[1]=1 for exactly this one cycle.
- WAIT: cycles L+1 .. L+CAP_OFS-1. cnt_ctrl_o[1]=0, bus_oe_o=0. This is the counter's release/turnaround window.
- DRIVE (cycle L+CAP_OFS): bus_oe_o=1 for exactly one cycle, bus_out_o = latched data. Counter samples at the end of this cycle.
- DONE (cycle L+CAP_OFS+1): done_o[winner]=1 and gnt_o drops.
- GAP: GAP cycles, then IDLE. GAP=0 goes straight to IDLE.
- Load bit spacing: next load rises no earlier than L+CAP_OFS+2+GAP, so a load pulse never restarts the counter mid-sequence.
- Round-robin arbitration:
  - Search starts at the pointer; the pointer moves to winner+1 (mod NREQ) on grant.
  - Requests arriving during busy wait. Same-cycle requests are resolved by the pointer.
- Data capture: data_i is sampled once at grant. Later changes are ignored.
- req_i dropped after grant: the sequence still completes and done_o still pulses (no abort).
- req_i still high the cycle after done_o: treated as a new request.
- run_i and drv_i are independent of the FSM and may change at any time.
- bus_oe_o is never high outside DRIVE.

Optional Feature:
- Macro PCLA_READBACK_EN.
- Defined:
  - Adds output err_o (1 bit, reset 0).
  - In DONE, count_i is compared with the latched data, allowing +1 if cnt_ctrl_o[0] was 1 during DRIVE.
  - On mismatch, err_o sets sticky until reset.
- Not defined: no err_o port and no compare logic. All other timing is identical.

Decomposition:
- Package prog_counter_load_pkg holds:
  - state enum pcla_state_t (IDLE, LOAD, WAIT, DRIVE, DONE, GAP);
  - ctrl bit index constants CTRL_EN=0, CTRL_LOAD=1, CTRL_OE=2;
  - CAP_OFS_DEFAULT=3.
- Sub-module pcla_rr_arb: combinational one-hot round-robin pick plus registered pointer, parameter NREQ.

Test Plan:
- Single request: req_i[0]=1, data 8'hA5 at cycle 0.
  - gnt_o=01 at cycle 1, load bit at cycle 1, bus_oe_o only at cycle 4 with bus_out_o=A5.
  - done_o[0] at cycle 5.
  - Counter model with en=0 shows count_i=A5.
- Simultaneous: req_i=11 with data 11/22, held.
  - Requester 0 served first (done cycle 5), then requester 1 with load bit at cycle 7 and done cycle 11.
  - Pointer alternates on repeated requests.
- Contention check, full sequence with counter model DEFAULT_DRIVE=1: counter oe and bus_oe_o are never both 1 in any cycle.
- Late request: req_i[1] rises during WAIT of requester 0. It is not granted until after GAP; its data is sampled at its own grant.
- Reset mid-sequence: rst_n low during DRIVE clears bus_oe_o, gnt_o and busy_o immediately, with no done_o. After release, the pending request restarts from IDLE.
- PCLA_READBACK_EN:
  - Counter model forced to capture 8'h00 instead of 5A -> err_o=1 at DONE, sticky.
  - Correct capture with en=1 (count_i=5B) -> err_o stays 0.

Source files
------------

// File: rtl/prog_counter_load_arbiter_pkg.sv
// Shared types and constants for the counter load-port arbiter.
package prog_counter_load_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_DRIVE,
        ST_DONE,
        ST_GAP
    } pcla_state_t;

    // Bit positions inside the counter's ui_in[2:0] control field
    localparam int CTRL_EN   = 0;
    localparam int CTRL_LOAD = 1;
    localparam int CTRL_OE   = 2;

    localparam int CAP_OFS_DEFAULT = 3;

endpackage

// File: rtl/prog_counter_load_arbiter_if.sv
// Requester-side bundle: level requests, packed load values, grant/done/busy.
interface prog_counter_load_arbiter_if #(parameter int NREQ = 2);
    logic [NREQ-1:0]       req_i;
    logic [NREQ-1:0][7:0]  data_i;
    logic [NREQ-1:0]       gnt_o;
    logic [NREQ-1:0]       done_o;
    logic                  busy_o;

    modport master (output req_i, data_i, input gnt_o, done_o, busy_o);
    modport slave  (input req_i, data_i, output gnt_o, done_o, busy_o);
endinterface

// File: rtl/prog_counter_load_arbiter_rr_arb.sv
// One-hot round-robin pick starting at ptr_q; pointer moves past the winner on adv.
module pcla_rr_arb
    import prog_counter_load_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            adv,
    output logic [NREQ-1:0] pick
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] idx;
    logic [PW-1:0] win;
    logic          found;

    always_comb begin
        pick  = '0;
        win   = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(ptr_q) + i) % NREQ);
            if (!found && req[idx]) begin
                found     = 1'b1;
                win       = idx;
                pick[idx] = 1'b1;
            end
        end
        ptr_d = (adv && found) ? PW'((int'(win) + 1) % NREQ) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/prog_counter_load_arbiter.sv
// Shares the counter load port between NREQ requesters; drives uio only in the capture cycle.
// Optional readback compare enabled by PCLA_READBACK_EN (adds sticky err_o).
module prog_counter_load_arbiter
    import prog_counter_load_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int CAP_OFS = CAP_OFS_DEFAULT,
    parameter int GAP     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_i,
    input  logic        drv_i,
    input  logic [7:0]  count_i,
    prog_counter_load_arbiter_if.slave req_if,
    output logic [2:0]  cnt_ctrl_o,
    output logic [7:0]  bus_out_o,
    output logic        bus_oe_o
`ifdef PCLA_READBACK_EN
    ,
    output logic        err_o
`endif
);
    localparam logic [7:0] WAIT_LAST = 8'(CAP_OFS - 2);
    localparam logic [7:0] GAP_LAST  = 8'(GAP - 1);

    pcla_state_t     state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] win_q, win_d;
    logic [7:0]      bus_out_q, bus_out_d;
    logic            run_q, drv_q;
    logic [NREQ-1:0] pick;
    logic [7:0]      data_sel;
    logic            fire;

    // A new grant may issue from IDLE or from the last GAP cycle, keeping load spacing tight
    assign fire = (|req_if.req_i) &&
                  ((state_q == ST_IDLE) || (state_q == ST_GAP && cnt_q == GAP_LAST));

    pcla_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req_if.req_i),
        .adv  (fire),
        .pick (pick)
    );

    always_comb begin
        data_sel = '0;
        for (int i = 0; i < NREQ; i++)
            if (pick[i]) data_sel |= req_if.data_i[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            win_q     <= '0;
            bus_out_q <= '0;
            run_q     <= 1'b0;
            drv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_q     <= win_d;
            bus_out_q <= bus_out_d;
            run_q     <= run_i;
            drv_q     <= drv_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        bus_out_d = bus_out_q;
        if (fire) begin
            win_d     = pick;
            bus_out_d = data_sel;
        end
        case (state_q)
            ST_IDLE:  if (fire) state_d = ST_LOAD;
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = (CAP_OFS > 1) ? ST_WAIT : ST_DRIVE;
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DRIVE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DRIVE: state_d = ST_DONE;
            ST_DONE: begin
                cnt_d   = '0;
                state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = fire ? ST_LOAD : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_ctrl_o           = '0;
        cnt_ctrl_o[CTRL_EN]  = run_q;
        cnt_ctrl_o[CTRL_OE]  = drv_q;
        bus_oe_o             = 1'b0;
        req_if.gnt_o         = '0;
        req_if.done_o        = '0;
        req_if.busy_o        = (state_q != ST_IDLE);
        case (state_q)
            ST_LOAD: begin
                cnt_ctrl_o[CTRL_LOAD] = 1'b1;
                req_if.gnt_o          = win_q;
            end
            ST_WAIT:  req_if.gnt_o = win_q;
            ST_DRIVE: begin
                req_if.gnt_o = win_q;
                bus_oe_o     = 1'b1;
            end
            ST_DONE:  req_if.done_o = win_q;
            default: ;
        endcase
    end

    assign bus_out_o = bus_out_q;

`ifdef PCLA_READBACK_EN
    logic err_q, err_d, en_drv_q, en_drv_d, mis;

    // Counter may already have counted once if enable was high while it captured
    always_comb begin
        mis = (state_q == ST_DONE) &&
              !((count_i == bus_out_q) || (en_drv_q && count_i == bus_out_q + 8'd1));
        err_d    = err_q | mis;
        en_drv_d = (state_q == ST_DRIVE) ? run_q : en_drv_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q    <= 1'b0;
            en_drv_q <= 1'b0;
        end else begin
            err_q    <= err_d;
            en_drv_q <= en_drv_d;
        end
    end

    assign err_o = err_q | mis;
`else
    logic unused_count;
    assign unused_count = ^count_i;
`endif
endmodule
